// File: rtl/uart_pkg.sv
// Shared constants and types for the fractional-N UART baud generator.
// Fixed point: divisor and accumulator carry FRAC_W fractional bits.
package uart_pkg;
   localparam int ACC_W      = 32;
   localparam int FRAC_W     = 8;
   localparam int OVERSAMPLE = 16;
   localparam int OS_W       = $clog2(OVERSAMPLE);

   typedef logic [ACC_W-1:0] div_t;
   typedef logic [OS_W-1:0]  os_cnt_t;

   localparam div_t    ONE     = div_t'(1) << FRAC_W;
   localparam div_t    MIN_DIV = ONE << 1;
   localparam os_cnt_t OS_LAST = os_cnt_t'(OVERSAMPLE - 1);
   localparam os_cnt_t OS_HALF = os_cnt_t'(OVERSAMPLE / 2);
endpackage

// File: rtl/uart_frac_accum.sv
// Phase accumulator, compare and active divisor for the baud generator.
// Optional resync input exists only when UART_BAUD_RESYNC_EN is defined.
module uart_frac_accum
   import uart_pkg::*;
(
   input  logic clk,
   input  logic reset,
`ifdef UART_BAUD_RESYNC_EN
   input  logic resync_i,
`endif
   input  logic enable_i,
   input  logic at_last_os_i,
   input  div_t div_shadow_i,
   output logic tick_raw_o,
   output logic div_err_o
);
   div_t           acc_q, acc_d;
   div_t           div_active_q, div_active_d;
   logic [ACC_W:0] sum;
   logic [ACC_W:0] diff;

   always_comb begin
      div_err_o    = (div_active_q < MIN_DIV);
      sum          = {1'b0, acc_q} + {1'b0, ONE};
      diff         = sum - {1'b0, div_active_q};
      acc_d        = acc_q;
      div_active_d = div_active_q;
      tick_raw_o   = 1'b0;
      if (!enable_i || div_err_o) begin
         // Idle or invalid divisor: keep tracking the shadow so a good load recovers.
         acc_d        = '0;
         div_active_d = div_shadow_i;
`ifdef UART_BAUD_RESYNC_EN
      end else if (resync_i) begin
         acc_d = '0;
`endif
      end else if (sum >= {1'b0, div_active_q}) begin
         acc_d      = diff[ACC_W-1:0];
         tick_raw_o = 1'b1;
         if (at_last_os_i) div_active_d = div_shadow_i;
      end else begin
         acc_d = sum[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q        <= '0;
         div_active_q <= MIN_DIV;
      end else begin
         acc_q        <= acc_d;
         div_active_q <= div_active_d;
      end
   end
endmodule

// File: rtl/uart_frac_baud_gen.sv
// Fractional-N UART tick generator: shadow divisor, oversample counter, output regs.
// Define UART_BAUD_RESYNC_EN to add the resync_i mid-bit realignment input.
module uart_frac_baud_gen
   import uart_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic enable_i,
   input  div_t divisor_i,
   input  logic load_i,
`ifdef UART_BAUD_RESYNC_EN
   input  logic resync_i,
`endif
   output logic tick_os_o,
   output logic tick_baud_o,
   output logic baud_out_o,
   output logic div_err_o
);
   div_t    div_shadow_q, div_shadow_d;
   os_cnt_t os_cnt_q, os_cnt_d;
   logic    tick_os_q, tick_os_d;
   logic    tick_baud_q, tick_baud_d;
   logic    baud_q, baud_d;
   logic    tick_raw, div_err;

   uart_frac_accum u_accum (
      .clk          (clk),
      .reset        (reset),
`ifdef UART_BAUD_RESYNC_EN
      .resync_i     (resync_i),
`endif
      .enable_i     (enable_i),
      .at_last_os_i (os_cnt_q == OS_LAST),
      .div_shadow_i (div_shadow_q),
      .tick_raw_o   (tick_raw),
      .div_err_o    (div_err)
   );

   always_comb begin
      div_shadow_d = load_i ? divisor_i : div_shadow_q;
      os_cnt_d     = os_cnt_q;
      tick_os_d    = 1'b0;
      tick_baud_d  = 1'b0;
      baud_d       = baud_q;
      if (!enable_i || div_err) begin
         os_cnt_d = '0;
         baud_d   = 1'b0;
`ifdef UART_BAUD_RESYNC_EN
      end else if (resync_i) begin
         // Restart half a bit in so the next bit tick lands mid-bit.
         os_cnt_d = OS_HALF;
         baud_d   = 1'b1;
`endif
      end else if (tick_raw) begin
         tick_os_d = 1'b1;
         if (os_cnt_q == OS_LAST) begin
            os_cnt_d    = '0;
            tick_baud_d = 1'b1;
            baud_d      = 1'b0;
         end else begin
            os_cnt_d = os_cnt_q + 1'b1;
            if (os_cnt_d == OS_HALF) baud_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_shadow_q <= MIN_DIV;
         os_cnt_q     <= '0;
         tick_os_q    <= 1'b0;
         tick_baud_q  <= 1'b0;
         baud_q       <= 1'b0;
      end else begin
         div_shadow_q <= div_shadow_d;
         os_cnt_q     <= os_cnt_d;
         tick_os_q    <= tick_os_d;
         tick_baud_q  <= tick_baud_d;
         baud_q       <= baud_d;
      end
   end

   assign tick_os_o   = tick_os_q;
   assign tick_baud_o = tick_baud_q;
   assign baud_out_o  = baud_q;
   assign div_err_o   = div_err;
endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Self-checking bench for uart_frac_baud_gen: divisor table plus corner-case sequences.
// Resync checks are included when UART_BAUD_RESYNC_EN is defined.
module tb_uart_frac_baud_gen;
   import uart_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic enable = 1'b0;
   logic load = 1'b0;
   div_t divisor = '0;
   logic tick_os, tick_baud, baud_out, div_err;
`ifdef UART_BAUD_RESYNC_EN
   logic resync = 1'b0;
`endif

   int total = 0;
   int bad = 0;

   typedef struct {
      div_t div;
      int   ncyc;
      int   exp_os;
      int   exp_baud;
      int   exp_hi;
      int   exp_err;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   uart_frac_baud_gen dut (
      .clk         (clk),
      .reset       (reset),
      .enable_i    (enable),
      .divisor_i   (divisor),
      .load_i      (load),
`ifdef UART_BAUD_RESYNC_EN
      .resync_i    (resync),
`endif
      .tick_os_o   (tick_os),
      .tick_baud_o (tick_baud),
      .baud_out_o  (baud_out),
      .div_err_o   (div_err)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reset, load d while disabled, allow one more cycle for the active copy.
   task automatic restart(input div_t d);
      enable = 1'b0;
      reset  = 1'b1;
      load   = 1'b0;
      cyc();
      reset   = 1'b0;
      load    = 1'b1;
      divisor = d;
      cyc();
      load = 1'b0;
      cyc();
   endtask

   initial begin
      int nos, nb, nhi, miss, pat, first;

      vecs[0] = '{32'h400, 128, 32, 2, 64, 0};
      vecs[1] = '{32'h280, 100, 40, 2, 41, 0};
      vecs[2] = '{32'h200,  64, 32, 2, 32, 0};
      vecs[3] = '{32'h300,  96, 32, 2, 48, 0};
      vecs[4] = '{32'h4C0,  76, 16, 1, 38, 0};
      vecs[5] = '{32'h100,  50,  0, 0,  0, 1};
      vecs[6] = '{32'h1FF,  50,  0, 0,  0, 1};
      vecs[7] = '{32'h000,  20,  0, 0,  0, 1};

      reset = 1'b1;
      cyc();
      cyc();
      chk("rst_tick_os", int'(tick_os), 0);
      chk("rst_tick_baud", int'(tick_baud), 0);
      chk("rst_baud_out", int'(baud_out), 0);
      chk("rst_div_err", int'(div_err), 0);

      for (int i = 0; i < NV; i++) begin
         restart(vecs[i].div);
         enable = 1'b1;
         nos = 0; nb = 0; nhi = 0;
         for (int c = 0; c < vecs[i].ncyc; c++) begin
            cyc();
            nos += int'(tick_os);
            nb  += int'(tick_baud);
            nhi += int'(baud_out);
         end
         chk($sformatf("v%0d_os_count", i), nos, vecs[i].exp_os);
         chk($sformatf("v%0d_baud_count", i), nb, vecs[i].exp_baud);
         chk($sformatf("v%0d_baud_hi", i), nhi, vecs[i].exp_hi);
         chk($sformatf("v%0d_div_err", i), int'(div_err), vecs[i].exp_err);
         enable = 1'b0;
      end

      // Divisor change mid-bit: two loads, last wins, applied at the bit tick.
      restart(32'h400);
      enable = 1'b1;
      miss = 0; nb = 0;
      for (int c = 1; c <= 200; c++) begin
         load    = (c == 20) || (c == 40);
         divisor = (c == 20) ? 32'h600 : 32'h800;
         cyc();
         if (int'(tick_os) != ((c <= 64) ? int'(c % 4 == 0) : int'((c - 64) % 8 == 0))) miss++;
         if (int'(tick_baud) != int'(c == 64 || c == 192)) nb++;
      end
      load = 1'b0;
      chk("switch_os_miss", miss, 0);
      chk("switch_baud_miss", nb, 0);

      // Invalid divisor suppresses ticks; a valid load while disabled recovers.
      restart(32'h100);
      enable = 1'b1;
      nos = 0;
      for (int c = 0; c < 20; c++) begin
         cyc();
         nos += int'(tick_os) + int'(tick_baud) + int'(baud_out);
      end
      chk("err_no_ticks", nos, 0);
      chk("err_flag", int'(div_err), 1);
      enable  = 1'b0;
      load    = 1'b1;
      divisor = 32'h200;
      cyc();
      load = 1'b0;
      cyc();
      chk("err_recovered", int'(div_err), 0);
      enable = 1'b1;
      miss = 0;
      for (int c = 1; c <= 20; c++) begin
         cyc();
         if (int'(tick_os) != int'(c % 2 == 0)) miss++;
      end
      chk("recover_os_miss", miss, 0);

      // Reset mid-bit on a cycle that would have ticked.
      restart(32'h400);
      enable = 1'b1;
      for (int c = 0; c < 35; c++) cyc();
      chk("pre_rst_baud_out", int'(baud_out), 1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("midrst_outputs", int'({tick_os, tick_baud, baud_out, div_err}), 0);
      pat = 0;
      for (int c = 0; c < 4; c++) begin
         cyc();
         pat = (pat << 1) | int'(tick_os);
      end
      chk("post_rst_default_div", pat, 4'b0101);
      enable  = 1'b0;
      load    = 1'b1;
      divisor = 32'h400;
      cyc();
      load = 1'b0;
      cyc();
      enable = 1'b1;
      pat = 0;
      for (int c = 0; c < 5; c++) begin
         cyc();
         pat = (pat << 1) | int'(tick_os);
      end
      chk("first_tick_latency", pat, 5'b00010);

`ifdef UART_BAUD_RESYNC_EN
      // Resync on a tick cycle: tick dropped, baud_out high, bit tick 32 clks later.
      restart(32'h400);
      enable = 1'b1;
      for (int c = 0; c < 35; c++) cyc();
      resync = 1'b1;
      cyc();
      resync = 1'b0;
      chk("resync_tick_dropped", int'(tick_os), 0);
      chk("resync_baud_out", int'(baud_out), 1);
      first = -1; nhi = 0; nos = 0;
      for (int c = 1; c <= 40; c++) begin
         cyc();
         if (tick_baud && first < 0) first = c;
         nhi += int'(baud_out);
         if (c <= 32) nos += int'(tick_os);
      end
      chk("resync_baud_delay", first, 32);
      chk("resync_baud_hi", nhi, 31);
      chk("resync_os_count", nos, 8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
